// File: rtl/axi4_lite_timer_slave_pkg.sv
// ----------------------------------------------------------------------------
// axi4_lite_timer_slave_pkg
// Shared definitions for the AXI4-Lite machine-timer slave: register offsets
// (ADDR[4:0] with the byte bits forced to zero), AXI response codes, CTRL bit
// indices, FSM state types and small decode/byte-merge helpers.
// No ports (package).
// ----------------------------------------------------------------------------
package axi4_lite_timer_slave_pkg;

    localparam logic [4:0] TMR_MTIME_LO = 5'h00;
    localparam logic [4:0] TMR_MTIME_HI = 5'h04;
    localparam logic [4:0] TMR_CMP_LO   = 5'h08;
    localparam logic [4:0] TMR_CMP_HI   = 5'h0C;
    localparam logic [4:0] TMR_CTRL     = 5'h10;
    localparam logic [4:0] TMR_PRESCALE = 5'h14;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // Offsets 0x18 and 0x1C are the only unmapped word slots.
    function automatic logic reg_is_mapped(input logic [4:0] off);
        return (off[4:3] != 2'b11);
    endfunction

    // Replace only the strobed bytes of a 32-bit word.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4_lite_timer_slave_if.sv
// ----------------------------------------------------------------------------
// axi4_lite_timer_slave_if
// AXI4-Lite bus bundle between the interconnect (master) and the timer slave.
// master modport: drives AW/W/AR channels and BREADY/RREADY.
// slave modport : drives the READY of AW/W/AR and the B/R response channels.
// ----------------------------------------------------------------------------
interface axi4_lite_timer_slave_if;
    logic [31:0] S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [31:0] S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/axi4_lite_timer_slave_timer_core.sv
// ----------------------------------------------------------------------------
// timer_core
// Prescaler, 64-bit mtime, 64-bit compare, CTRL/PRESCALE registers and the
// registered level interrupt.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   *_we                    : one-cycle write enables per register
//   wr_data, wr_strb        : write data and byte strobes for the enabled reg
//   mtime, cmp              : current 64-bit timer and compare values
//   ctrl_en, ctrl_irq_en    : CTRL.EN and CTRL.IRQ_EN
//   prescale                : PRESCALE register
//   timer_irq               : IRQ_EN & (mtime >= cmp), one cycle late
// ----------------------------------------------------------------------------
module timer_core
    import axi4_lite_timer_slave_pkg::*;
#(
    parameter logic [15:0] PRESCALE_RST = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mtime_lo_we,
    input  logic        mtime_hi_we,
    input  logic        cmp_lo_we,
    input  logic        cmp_hi_we,
    input  logic        ctrl_we,
    input  logic        prescale_we,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    output logic [63:0] mtime,
    output logic [63:0] cmp,
    output logic        ctrl_en,
    output logic        ctrl_irq_en,
    output logic [15:0] prescale,
    output logic        timer_irq
);

    logic [15:0] presc_cnt;
    logic        tick;

    assign tick = ctrl_en && (presc_cnt == prescale);

    // A software write to either mtime half suppresses that cycle's tick, so
    // bytes not written keep their pre-tick value, and restarts the prescaler.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime       <= 64'd0;
            cmp         <= 64'hFFFF_FFFF_FFFF_FFFF;
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            prescale    <= PRESCALE_RST;
            presc_cnt   <= 16'd0;
            timer_irq   <= 1'b0;
        end else begin
            if (mtime_lo_we || mtime_hi_we) begin
                presc_cnt <= 16'd0;
                if (mtime_lo_we) mtime[31:0]  <= apply_strb(mtime[31:0], wr_data, wr_strb);
                if (mtime_hi_we) mtime[63:32] <= apply_strb(mtime[63:32], wr_data, wr_strb);
            end else if (ctrl_en) begin
                if (tick) begin
                    presc_cnt <= 16'd0;
                    mtime     <= mtime + 64'd1;
                end else begin
                    presc_cnt <= presc_cnt + 16'd1;
                end
            end

            if (cmp_lo_we) cmp[31:0]  <= apply_strb(cmp[31:0], wr_data, wr_strb);
            if (cmp_hi_we) cmp[63:32] <= apply_strb(cmp[63:32], wr_data, wr_strb);

            if (ctrl_we && wr_strb[0]) begin
                ctrl_en     <= wr_data[CTRL_EN_BIT];
                ctrl_irq_en <= wr_data[CTRL_IRQ_EN_BIT];
            end

            if (prescale_we && wr_strb[0]) prescale[7:0]  <= wr_data[7:0];
            if (prescale_we && wr_strb[1]) prescale[15:8] <= wr_data[15:8];

            timer_irq <= ctrl_irq_en && (mtime >= cmp);
        end
    end

endmodule

// File: rtl/axi4_lite_timer_slave.sv
// ----------------------------------------------------------------------------
// axi4_lite_timer_slave
// AXI4-Lite slave wrapping a RISC-V machine timer.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   s_axi     : AXI4-Lite slave bus (only ADDR[4:2] decoded, PROT ignored)
//   timer_irq : registered level timer interrupt
// Holds the independent write/read FSMs, address decode and the MTIME_HI
// shadow used for coherent 64-bit reads.
// ----------------------------------------------------------------------------
module axi4_lite_timer_slave
    import axi4_lite_timer_slave_pkg::*;
#(
    parameter logic [15:0] PRESCALE_RST = 16'd0
) (
    input  logic                   clk,
    input  logic                   rst,
    axi4_lite_timer_slave_if.slave s_axi,
    output logic                   timer_irq
);

    wr_state_t   w_state, w_state_next;
    logic        aw_got, aw_got_next, w_got, w_got_next;
    logic [4:0]  aw_off_q, aw_off_next, aw_off_in;
    logic [31:0] wdata_q, wdata_next;
    logic [3:0]  wstrb_q, wstrb_next;
    logic        awready_q, awready_next, wready_q, wready_next;
    logic [1:0]  bresp_q, bresp_next;
    logic        aw_hs, w_hs, commit;

    rd_state_t   r_state, r_state_next;
    logic        arready_q, arready_next, ar_hs;
    logic [4:0]  ar_off;
    logic [31:0] rdata_q, rdata_next, hi_shadow, hi_shadow_next, ctrl_word;
    logic [1:0]  rresp_q, rresp_next;

    logic [63:0] mtime, cmp;
    logic        ctrl_en, ctrl_irq_en;
    logic [15:0] prescale;
    logic        unused_bits;

    assign unused_bits = &{1'b0, s_axi.S_AXI_AWADDR[31:5], s_axi.S_AXI_AWADDR[1:0],
                           s_axi.S_AXI_ARADDR[31:5], s_axi.S_AXI_ARADDR[1:0],
                           s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

    assign aw_hs     = s_axi.S_AXI_AWVALID && awready_q;
    assign w_hs      = s_axi.S_AXI_WVALID && wready_q;
    assign ar_hs     = s_axi.S_AXI_ARVALID && arready_q;
    assign aw_off_in = {s_axi.S_AXI_AWADDR[4:2], 2'b00};
    assign ar_off    = {s_axi.S_AXI_ARADDR[4:2], 2'b00};

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = (w_state == W_RESP);
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = (r_state == R_DATA);
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_off_q  <= 5'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bresp_q   <= AXI_RESP_OKAY;
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= AXI_RESP_OKAY;
            hi_shadow <= 32'd0;
        end else begin
            w_state   <= w_state_next;
            aw_got    <= aw_got_next;
            w_got     <= w_got_next;
            aw_off_q  <= aw_off_next;
            wdata_q   <= wdata_next;
            wstrb_q   <= wstrb_next;
            awready_q <= awready_next;
            wready_q  <= wready_next;
            bresp_q   <= bresp_next;
            r_state   <= r_state_next;
            arready_q <= arready_next;
            rdata_q   <= rdata_next;
            rresp_q   <= rresp_next;
            hi_shadow <= hi_shadow_next;
        end
    end

    // Write side: AW and W are latched independently; the *_next copies merge
    // a same-cycle handshake with an earlier one, so they also feed the commit.
    always_comb begin
        w_state_next = w_state;
        aw_got_next  = aw_got;
        w_got_next   = w_got;
        aw_off_next  = aw_off_q;
        wdata_next   = wdata_q;
        wstrb_next   = wstrb_q;
        bresp_next   = bresp_q;
        commit       = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_got_next = 1'b1;
                    aw_off_next = aw_off_in;
                end
                if (w_hs) begin
                    w_got_next = 1'b1;
                    wdata_next = s_axi.S_AXI_WDATA;
                    wstrb_next = s_axi.S_AXI_WSTRB;
                end
                if (aw_got_next && w_got_next) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                    aw_got_next  = 1'b0;
                    w_got_next   = 1'b0;
                    bresp_next   = reg_is_mapped(aw_off_next) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                end
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) w_state_next = W_IDLE;
            end
        endcase
        awready_next = (w_state_next == W_IDLE) && !aw_got_next;
        wready_next  = (w_state_next == W_IDLE) && !w_got_next;
    end

    always_comb begin
        ctrl_word                  = 32'd0;
        ctrl_word[CTRL_EN_BIT]     = ctrl_en;
        ctrl_word[CTRL_IRQ_EN_BIT] = ctrl_irq_en;
    end

    // Read side: a MTIME_LO read snapshots the live upper half so a following
    // MTIME_HI read is coherent with it even across a carry.
    always_comb begin
        r_state_next   = r_state;
        rdata_next     = rdata_q;
        rresp_next     = rresp_q;
        hi_shadow_next = hi_shadow;
        case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_next = R_DATA;
                    rresp_next   = reg_is_mapped(ar_off) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                    case (ar_off)
                        TMR_MTIME_LO: begin
                            rdata_next     = mtime[31:0];
                            hi_shadow_next = mtime[63:32];
                        end
                        TMR_MTIME_HI: rdata_next = hi_shadow;
                        TMR_CMP_LO:   rdata_next = cmp[31:0];
                        TMR_CMP_HI:   rdata_next = cmp[63:32];
                        TMR_CTRL:     rdata_next = ctrl_word;
                        TMR_PRESCALE: rdata_next = {16'd0, prescale};
                        default:      rdata_next = 32'd0;
                    endcase
                end
            end
            R_DATA: begin
                if (s_axi.S_AXI_RREADY) r_state_next = R_IDLE;
            end
        endcase
        arready_next = (r_state_next == R_IDLE);
    end

    timer_core #(
        .PRESCALE_RST (PRESCALE_RST)
    ) u_timer_core (
        .clk         (clk),
        .rst         (rst),
        .mtime_lo_we (commit && (aw_off_next == TMR_MTIME_LO)),
        .mtime_hi_we (commit && (aw_off_next == TMR_MTIME_HI)),
        .cmp_lo_we   (commit && (aw_off_next == TMR_CMP_LO)),
        .cmp_hi_we   (commit && (aw_off_next == TMR_CMP_HI)),
        .ctrl_we     (commit && (aw_off_next == TMR_CTRL)),
        .prescale_we (commit && (aw_off_next == TMR_PRESCALE)),
        .wr_data     (wdata_next),
        .wr_strb     (wstrb_next),
        .mtime       (mtime),
        .cmp         (cmp),
        .ctrl_en     (ctrl_en),
        .ctrl_irq_en (ctrl_irq_en),
        .prescale    (prescale),
        .timer_irq   (timer_irq)
    );

endmodule

// File: tb/tb_axi4_lite_timer_slave.sv
// ----------------------------------------------------------------------------
// tb_axi4_lite_timer_slave
// Directed self-checking bench for the AXI4-Lite machine-timer slave.
// A free-running edge counter (cyc) time-stamps register commits and read
// address handshakes, so expected mtime values follow from the prescaler
// rule; the interrupt level after every edge is logged in irq_at[].
// ----------------------------------------------------------------------------
module tb_axi4_lite_timer_slave;

    logic clk = 1'b0;
    logic rst;
    logic irq;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic irq_at [0:8191];

    axi4_lite_timer_slave_if bus ();

    axi4_lite_timer_slave #(
        .PRESCALE_RST (16'd0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_axi     (bus.slave),
        .timer_irq (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < 8192) irq_at[cyc] = irq;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "[TB] watchdog");
    end

    // Full write: AW and W together, BREADY high; returns BRESP and the edge
    // index on which the register update committed.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output int commit_cyc);
        bit aw_done, w_done, aw_take, w_take;
        int n;
        aw_done = 0; w_done = 0; n = 0; resp = 2'b11; commit_cyc = 0;
        @(negedge clk);
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = data;
        bus.S_AXI_WSTRB   = strb;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_BREADY  = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_take = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_take  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(posedge clk); #1;
            if (aw_take) begin bus.S_AXI_AWVALID = 1'b0; aw_done = 1; end
            if (w_take)  begin bus.S_AXI_WVALID  = 1'b0; w_done  = 1; end
            n++;
            if (!(aw_done && w_done)) @(negedge clk);
        end
        commit_cyc = cyc;
        n = 0;
        @(negedge clk);
        while (!bus.S_AXI_BVALID && n < 20) begin @(negedge clk); n++; end
        if (!bus.S_AXI_BVALID) begin
            tests++; fails++;
            $display("[TB] FAIL write_timeout addr=%h: got no BVALID required BVALID=1", addr);
            bus.S_AXI_AWVALID = 1'b0;
            bus.S_AXI_WVALID  = 1'b0;
        end else begin
            resp = bus.S_AXI_BRESP;
        end
        @(posedge clk); #1;
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [1:0] r;
        int c;
        axi_write(addr, data, 4'hF, r, c);
    endtask

    // Full read with RREADY high; returns data, response and the edge index
    // of the AR handshake.
    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int ar_cyc);
        int n;
        n = 0; data = 32'hXXXX_XXXX; resp = 2'b11; ar_cyc = 0;
        @(negedge clk);
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = 1'b1;
        while (!bus.S_AXI_ARREADY && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        ar_cyc = cyc;
        bus.S_AXI_ARVALID = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.S_AXI_RVALID && n < 20) begin @(negedge clk); n++; end
        if (!bus.S_AXI_RVALID) begin
            tests++; fails++;
            $display("[TB] FAIL read_timeout addr=%h: got no RVALID required RVALID=1", addr);
        end else begin
            data = bus.S_AXI_RDATA;
            resp = bus.S_AXI_RRESP;
        end
        @(posedge clk); #1;
        bus.S_AXI_RREADY = 1'b0;
    endtask

    // Stop the timer, load PRESCALE and mtime, then write CTRL; en_cyc is the
    // edge on which CTRL took effect (prescale counter is 0 at that point).
    task automatic setup_timer(input logic [31:0] hi, input logic [31:0] lo,
                               input logic [31:0] presc, input logic [31:0] ctrl,
                               output int en_cyc);
        logic [1:0] r;
        wr(32'h10, 32'h0);
        wr(32'h14, presc);
        wr(32'h04, hi);
        wr(32'h00, lo);
        axi_write(32'h10, ctrl, 4'hF, r, en_cyc);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        int          c;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_ARREADY,
             bus.S_AXI_RVALID, irq} !== 6'b0) begin
            fails++;
            $display("[TB] FAIL reset_handshake: got %b required 000000",
                     {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
                      bus.S_AXI_ARREADY, bus.S_AXI_RVALID, irq});
        end
        tests++;
        if ({bus.S_AXI_RDATA, bus.S_AXI_RRESP, bus.S_AXI_BRESP} !== 36'd0) begin
            fails++;
            $display("[TB] FAIL reset_data: got %h required 0",
                     {bus.S_AXI_RDATA, bus.S_AXI_RRESP, bus.S_AXI_BRESP});
        end
        rst = 1'b0;
        axi_read(32'h08, d, r, c);
        tests++;
        if (d !== 32'hFFFF_FFFF || r !== 2'b00) begin
            fails++;
            $display("[TB] FAIL reset_cmp_lo: got %h/%b required ffffffff/00", d, r);
        end
        axi_read(32'h14, d, r, c);
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_prescale: got %h required 00000000", d);
        end
    endtask

    task automatic test_count10();
        logic [31:0] d;
        logic [1:0]  r;
        int          p, q;
        axi_write(32'h10, 32'h1, 4'hF, r, p);
        repeat (10) @(posedge clk);
        axi_read(32'h00, d, r, q);
        tests++;
        if (d !== 32'(q - 1 - p) || r !== 2'b00) begin
            fails++;
            $display("[TB] FAIL count10_mtime_lo: got %0d/%b required %0d/00", d, r, q - 1 - p);
        end
    endtask

    task automatic test_prescale();
        logic [31:0] d;
        logic [1:0]  r;
        int          p, q;
        setup_timer(32'h0, 32'h0, 32'h3, 32'h1, p);
        for (int k = 0; k < 3; k++) begin
            repeat (k * 3 + 2) @(posedge clk);
            axi_read(32'h00, d, r, q);
            tests++;
            if (d !== 32'((q - 1 - p) / 4)) begin
                fails++;
                $display("[TB] FAIL prescale3_mtime[%0d]: got %0d required %0d",
                         k, d, (q - 1 - p) / 4);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic [1:0]  r;
        logic [63:0] m;
        int          p, q, c;
        setup_timer(32'h0, 32'hFFFF_FFFE, 32'h0, 32'h1, p);
        repeat (4) @(posedge clk);
        axi_read(32'h00, d, r, q);
        m = 64'hFFFF_FFFE + 64'(q - 1 - p);
        tests++;
        if (d !== m[31:0]) begin
            fails++;
            $display("[TB] FAIL wrap_lo: got %h required %h", d, m[31:0]);
        end
        axi_read(32'h04, d, r, c);
        tests++;
        if (d !== m[63:32] || d !== 32'h1) begin
            fails++;
            $display("[TB] FAIL wrap_hi: got %h required %h", d, m[63:32]);
        end
    endtask

    task automatic test_shadow();
        logic [31:0] d;
        logic [1:0]  r;
        logic [63:0] m;
        int          p, q, c;
        setup_timer(32'h0, 32'hFFFF_FFF0, 32'h0, 32'h1, p);
        axi_read(32'h00, d, r, q);
        m = 64'hFFFF_FFF0 + 64'(q - 1 - p);
        repeat (30) @(posedge clk);
        axi_read(32'h04, d, r, c);
        tests++;
        if (d !== m[63:32] || d !== 32'h0) begin
            fails++;
            $display("[TB] FAIL shadow_hi_old: got %h required %h", d, m[63:32]);
        end
        axi_read(32'h00, d, r, q);
        m = 64'hFFFF_FFF0 + 64'(q - 1 - p);
        tests++;
        if (d !== m[31:0]) begin
            fails++;
            $display("[TB] FAIL shadow_lo_new: got %h required %h", d, m[31:0]);
        end
        axi_read(32'h04, d, r, c);
        tests++;
        if (d !== m[63:32]) begin
            fails++;
            $display("[TB] FAIL shadow_hi_new: got %h required %h", d, m[63:32]);
        end
    endtask

    task automatic test_irq();
        logic [1:0] r;
        int         p, c;
        wr(32'h0C, 32'h0);
        wr(32'h08, 32'd20);
        setup_timer(32'h0, 32'h0, 32'h0, 32'h3, p);
        while (cyc < p + 26) @(posedge clk);
        @(negedge clk);
        tests++;
        if (irq_at[p + 1] !== 1'b0 || irq_at[p + 20] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL irq_before_match: got %b,%b required 0,0",
                     irq_at[p + 1], irq_at[p + 20]);
        end
        tests++;
        if (irq_at[p + 21] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL irq_rise: got %b required 1", irq_at[p + 21]);
        end
        axi_write(32'h0C, 32'h1, 4'hF, r, c);
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (irq_at[c] !== 1'b1 || irq_at[c + 1] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL irq_clear: got %b,%b required 1,0", irq_at[c], irq_at[c + 1]);
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d;
        logic [1:0]  r, bresp;
        int          n, held, c;
        @(negedge clk);
        bus.S_AXI_WDATA  = 32'hA5A5_0001;
        bus.S_AXI_WSTRB  = 4'hF;
        bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_BREADY = 1'b0;
        n = 0;
        while (!bus.S_AXI_WREADY && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.S_AXI_WVALID = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.S_AXI_WREADY, bus.S_AXI_AWREADY, bus.S_AXI_BVALID} !== 3'b010) begin
            fails++;
            $display("[TB] FAIL w_only_state: got %b required 010",
                     {bus.S_AXI_WREADY, bus.S_AXI_AWREADY, bus.S_AXI_BVALID});
        end
        repeat (2) @(negedge clk);
        bus.S_AXI_AWADDR  = 32'h08;
        bus.S_AXI_AWVALID = 1'b1;
        n = 0;
        while (!bus.S_AXI_AWREADY && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0;
        held = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.S_AXI_BVALID === 1'b1 && bus.S_AXI_AWREADY === 1'b0) held++;
        end
        tests++;
        if (held != 5) begin
            fails++;
            $display("[TB] FAIL bvalid_held: got %0d cycles required 5", held);
        end
        bresp = bus.S_AXI_BRESP;
        bus.S_AXI_BREADY = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_BREADY = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bresp} !== 5'b01100) begin
            fails++;
            $display("[TB] FAIL after_bresp: got %b required 01100",
                     {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bresp});
        end
        axi_read(32'h08, d, r, c);
        tests++;
        if (d !== 32'hA5A5_0001) begin
            fails++;
            $display("[TB] FAIL w_before_aw_data: got %h required a5a50001", d);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic [1:0]  r;
        int          c;
        axi_write(32'h18, 32'hDEAD_BEEF, 4'hF, r, c);
        tests++;
        if (r !== 2'b10) begin
            fails++;
            $display("[TB] FAIL unmapped_bresp: got %b required 10", r);
        end
        axi_read(32'h1C, d, r, c);
        tests++;
        if (d !== 32'h0 || r !== 2'b10) begin
            fails++;
            $display("[TB] FAIL unmapped_read: got %h/%b required 00000000/10", d, r);
        end
        axi_read(32'h10, d, r, c);
        tests++;
        if (d !== 32'h3 || r !== 2'b00) begin
            fails++;
            $display("[TB] FAIL ctrl_read: got %h/%b required 00000003/00", d, r);
        end
    endtask

    task automatic test_wstrb();
        logic [31:0] d;
        logic [1:0]  r;
        int          c;
        wr(32'h10, 32'h0);
        wr(32'h14, 32'h0000_00AB);
        axi_write(32'h14, 32'hFFFF_55CD, 4'b0010, r, c);
        axi_read(32'h14, d, r, c);
        tests++;
        if (d !== 32'h0000_55AB) begin
            fails++;
            $display("[TB] FAIL wstrb_prescale: got %h required 000055ab", d);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d;
        logic [1:0]  r;
        int          n, c;
        @(negedge clk);
        bus.S_AXI_AWADDR  = 32'h08;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = 32'h1234_5678;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_BREADY  = 1'b0;
        n = 0;
        while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY) && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.S_AXI_BVALID !== 1'b1) begin
            fails++;
            $display("[TB] FAIL abort_pending_b: got %b required 1", bus.S_AXI_BVALID);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL abort_in_reset: got %b required 00",
                     {bus.S_AXI_BVALID, bus.S_AXI_AWREADY});
        end
        rst = 1'b0;
        bus.S_AXI_BREADY = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY} !== 2'b01) begin
            fails++;
            $display("[TB] FAIL abort_after_reset: got %b required 01",
                     {bus.S_AXI_BVALID, bus.S_AXI_AWREADY});
        end
        bus.S_AXI_BREADY = 1'b0;
        axi_read(32'h08, d, r, c);
        tests++;
        if (d !== 32'hFFFF_FFFF) begin
            fails++;
            $display("[TB] FAIL abort_cmp_reset: got %h required ffffffff", d);
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.S_AXI_AWADDR  = 32'h0;
        bus.S_AXI_AWPROT  = 3'h0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = 32'h0;
        bus.S_AXI_WSTRB   = 4'h0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b0;
        bus.S_AXI_ARADDR  = 32'h0;
        bus.S_AXI_ARPROT  = 3'h0;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b0;

        test_reset();
        test_count10();
        test_prescale();
        test_wrap();
        test_shadow();
        test_irq();
        test_w_before_aw();
        test_errors();
        test_wstrb();
        test_reset_abort();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
